dm_message_checker: RTL and testbench
=====================================

// Module: dm_message_checker
// PURPOSE
//   Reader at the far end of the decrypted-message memory (DM): after the decrypt loop has
//   written DM, this block scans the first MSG_LEN bytes and reports whether every byte is
//   a legal plaintext character (lowercase a-z or space). It is the plaintext validity check
//   for key search; the top level muxes DM address ownership to this block while rd_active=1.
// PARAMETERS
//   MSG_LEN     32     bytes to check, DM addresses 0..MSG_LEN-1; legal range 1..256
//   ADDR_W      8      DM address width
//   DATA_W      8      DM data width
//   LO_CHAR     8'h61  lowest legal letter ('a')
//   HI_CHAR     8'h7A  highest legal letter ('z')
//   SPACE_CHAR  8'h20  additional legal character (space)
// PORTS
//   clk          in   1       system clock (CLOCK_50 at top level)
//   reset_n      in   1       synchronous active-low reset
//   start_flag   in   1       level request, driven by decrypt loop done_flag
//   addr_dec     out  ADDR_W  DM read address
//   rddata_dec   in   DATA_W  DM q; valid in the cycle after addr_dec is clocked into RAM
//   rd_active    out  1       high in READ/WAIT/CHECK; top selects addr_dec onto DM
//   done_flag    out  1       high while in DONE
//   valid_flag   out  1       1 = all MSG_LEN bytes legal; meaningful when done_flag=1
//   bad_index    out  ADDR_W  index of first illegal byte; 0 when valid_flag=1
// BEHAVIOUR
//   - Read-only: no DM write port; DM wren stays owned by the decrypt loop.
//   - Reset (reset_n=0 at an edge): state IDLE, addr_dec=0, rd_active=0, done_flag=0,
//     valid_flag=0, bad_index=0, idx=0. Applies mid-scan; the scan is abandoned.
//   - FSM: IDLE, READ, WAIT, CHECK, DONE. Three cycles per byte.
//   - IDLE: start_flag=1 at an edge -> READ; idx=0, addr_dec=0, valid_flag=0, bad_index=0.
//   - READ: addr_dec=idx presented; -> WAIT.   WAIT: RAM latency cycle; -> CHECK.
//   - CHECK: rddata_dec sampled at the end of this cycle. Byte legal iff
//     (LO_CHAR <= b <= HI_CHAR) or b == SPACE_CHAR, unsigned compare.
//     legal and idx <  MSG_LEN-1 -> idx+1, addr_dec+1, READ.
//     legal and idx == MSG_LEN-1 -> valid_flag=1, bad_index=0, DONE.
//     illegal                    -> valid_flag=0, bad_index=idx, DONE (early exit).
//   - Latency: start sampled at edge 0; done_flag first high in the cycle after edge 3*(k+1),
//     k = index of last byte examined (3*MSG_LEN for a fully legal message).
//   - DONE: done_flag=1, rd_active=0, addr_dec holds last value. Stays in DONE while
//     start_flag=1 (no retrigger on held level). start_flag=0 -> IDLE: done_flag drops;
//     valid_flag and bad_index keep their values until the next start.
//   - idx never exceeds MSG_LEN-1; MSG_LEN=256 uses the full 8-bit range without wrap.
//   - start_flag changes outside IDLE/DONE are ignored.
// TESTING
//   1. DM[0..31]=8'h61, start_flag held 1 -> addr_dec 0..31 in order, done_flag high after
//      edge 96, valid_flag=1, bad_index=0.
//   2. DM[5]=8'h41 ('A'), others 8'h61 -> done after edge 18, valid_flag=0, bad_index=5,
//      addresses above 5 never presented.
//   3. Boundaries at DM[0]: 8'h20, 8'h61, 8'h7A each pass; 8'h1F, 8'h60, 8'h7B each fail
//      -> done after edge 3, bad_index=0.
//   4. DM[31]=8'h7B, others legal -> done after edge 96, valid_flag=0, bad_index=31.
//   5. reset_n=0 for one edge at cycle 40 -> next cycle IDLE, addr_dec=0, rd_active=0,
//      done_flag=0; release and restart -> test 1 result reproduced exactly.
//   6. start_flag held 1 for 20 cycles past done -> no rescan; drop 1 cycle, raise again ->
//      second scan with identical address sequence and results.

Source files
------------

// File: rtl/dm_message_checker_if.sv
// Read-only bus between the message checker and the decrypted-message memory.
// The checker drives the address and the ownership request; the memory side
// returns the read data one clock after the address is registered.
interface dm_message_checker_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr_dec;
  logic [DATA_W-1:0] rddata_dec;
  logic              rd_active;

  modport master (
    output addr_dec,
    output rd_active,
    input  rddata_dec
  );

  modport slave (
    input  addr_dec,
    input  rd_active,
    output rddata_dec
  );
endinterface

// File: rtl/dm_message_checker.sv
// Plaintext validity scanner for the decrypted-message memory.
// Walks DM addresses 0..MSG_LEN-1, three cycles per byte (present address,
// wait for RAM, check data), and stops at the first byte that is neither a
// lowercase letter nor a space. The result is held after the scan until the
// next start so the key-search controller can read it at leisure.
module dm_message_checker #(
  parameter int                MSG_LEN    = 32,
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] LO_CHAR    = 8'h61,
  parameter logic [DATA_W-1:0] HI_CHAR    = 8'h7A,
  parameter logic [DATA_W-1:0] SPACE_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_flag,
  dm_message_checker_if.master   dm,
  output logic                   done_flag,
  output logic                   valid_flag,
  output logic [ADDR_W-1:0]      bad_index
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic              byte_legal;

  // Character class test on the byte returned by the memory.
  always_comb begin
    byte_legal = ((dm.rddata_dec >= LO_CHAR) && (dm.rddata_dec <= HI_CHAR)) ||
                 (dm.rddata_dec == SPACE_CHAR);
  end

  // Next-state and scan bookkeeping; a held start level never retriggers from DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (start_flag) begin
          state_d = READ;
          idx_d   = '0;
          addr_d  = '0;
          valid_d = 1'b0;
          bad_d   = '0;
        end
      end
      READ:  state_d = WAIT;
      WAIT:  state_d = CHECK;
      CHECK: begin
        if (!byte_legal) begin
          valid_d = 1'b0;
          bad_d   = idx_q;
          state_d = DONE;
        end else if (idx_q == LAST_IDX) begin
          valid_d = 1'b1;
          bad_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = READ;
        end
      end
      DONE: begin
        if (!start_flag) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any scan in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
    end
  end

  // Output decode; DM ownership is requested only while bytes are being read.
  always_comb begin
    dm.addr_dec  = addr_q;
    dm.rd_active = (state_q == READ) || (state_q == WAIT) || (state_q == CHECK);
    done_flag    = (state_q == DONE);
    valid_flag   = valid_q;
    bad_index    = bad_q;
  end

endmodule

// File: tb/tb_dm_message_checker.sv
// Bench for dm_message_checker: a synchronous RAM model feeds the checker and
// a reference model (first illegal byte in the message) predicts latency,
// address sequence and results for directed and random messages.
module tb_dm_message_checker;

  localparam int MSG_LEN = 32;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_flag;
  logic       done_flag;
  logic       valid_flag;
  logic [7:0] bad_index;
  logic [7:0] mem [0:255];
  int         compared   = 0;
  int         mismatched = 0;

  dm_message_checker_if #(.ADDR_W(8), .DATA_W(8)) dm ();

  dm_message_checker #(
    .MSG_LEN(MSG_LEN), .ADDR_W(8), .DATA_W(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_flag(start_flag),
    .dm        (dm.master),
    .done_flag (done_flag),
    .valid_flag(valid_flag),
    .bad_index (bad_index)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Synchronous-read RAM: q follows the address registered at the previous edge
  always @(posedge clk) dm.rddata_dec <= mem[dm.addr_dec];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit isLegal(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) || (b == 8'h20);
  endfunction

  // Reference model: index of the first illegal byte, -1 for a clean message
  function automatic int firstBad();
    for (int i = 0; i < MSG_LEN; i++) begin
      if (!isLegal(mem[i])) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] legalByte();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] illegalByte();
    logic [7:0] b;
    do b = 8'($urandom); while (isLegal(b));
    return b;
  endfunction

  task automatic fillConst(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = (i < MSG_LEN) ? v : illegalByte();
  endtask

  // Run one scan from IDLE; optionally leave start high afterwards
  task automatic applyStimulus(input string tag, input bit holdStart);
    int k, lastIdx, expCycles, cycles, active, seqErr;
    logic expValid;
    logic [7:0] expBad;
    k         = firstBad();
    lastIdx   = (k < 0) ? MSG_LEN - 1 : k;
    expCycles = 3 * (lastIdx + 1) + 1;
    expValid  = (k < 0);
    expBad    = (k < 0) ? 8'd0 : 8'(k);
    cycles = 0; active = 0; seqErr = 0;
    @(negedge clk);
    start_flag = 1'b1;
    while (!done_flag && cycles < 3 * MSG_LEN + 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (dm.rd_active) begin
        if (dm.addr_dec != 8'(active / 3)) seqErr++;
        active++;
      end
    end
    checkOutput({tag, "_done"}, 32'(done_flag), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expCycles));
    checkOutput({tag, "_active_cycles"}, 32'(active), 32'(3 * (lastIdx + 1)));
    checkOutput({tag, "_addr_seq_errors"}, 32'(seqErr), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valid_flag), 32'(expValid));
    checkOutput({tag, "_bad_index"}, 32'(bad_index), 32'(expBad));
    checkOutput({tag, "_addr_hold"}, 32'(dm.addr_dec), 32'(lastIdx));
    if (!holdStart) begin
      start_flag = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_done_drop"}, 32'(done_flag), 32'd0);
      checkOutput({tag, "_valid_kept"}, 32'(valid_flag), 32'(expValid));
      checkOutput({tag, "_bad_kept"}, 32'(bad_index), 32'(expBad));
    end
  endtask

  initial begin
    int errs;
    reset_n    = 1'b0;
    start_flag = 1'b0;
    fillConst(8'h61);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_done", 32'(done_flag), 32'd0);
    checkOutput("rst_active", 32'(dm.rd_active), 32'd0);
    checkOutput("rst_addr", 32'(dm.addr_dec), 32'd0);
    checkOutput("rst_valid", 32'(valid_flag), 32'd0);
    checkOutput("rst_bad", 32'(bad_index), 32'd0);
    reset_n = 1'b1;

    // Clean message of all 'a'
    fillConst(8'h61);
    applyStimulus("all_a", 1'b0);

    // Uppercase at index 5
    fillConst(8'h61);
    mem[5] = 8'h41;
    applyStimulus("upper5", 1'b0);

    // Character-class boundaries at index 0
    begin
      logic [7:0] edgeVals [6];
      edgeVals = '{8'h20, 8'h61, 8'h7A, 8'h1F, 8'h60, 8'h7B};
      for (int i = 0; i < 6; i++) begin
        fillConst(8'h61);
        mem[0] = edgeVals[i];
        applyStimulus($sformatf("edge_%02h", edgeVals[i]), 1'b0);
      end
    end

    // Illegal last byte
    fillConst(8'h61);
    mem[MSG_LEN-1] = 8'h7B;
    applyStimulus("last_bad", 1'b0);

    // Random messages, some clean, some with one illegal byte
    for (int t = 0; t < 10; t++) begin
      fillConst(8'h61);
      for (int i = 0; i < MSG_LEN; i++) mem[i] = legalByte();
      if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, MSG_LEN - 1)] = illegalByte();
      applyStimulus($sformatf("rand%0d", t), 1'b0);
    end

    // Reset in the middle of a scan, then a clean rerun
    fillConst(8'h61);
    applyStimulus("pre_reset", 1'b0);
    @(negedge clk);
    start_flag = 1'b1;
    repeat (40) @(negedge clk);
    reset_n    = 1'b0;
    start_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_done", 32'(done_flag), 32'd0);
    checkOutput("midrst_active", 32'(dm.rd_active), 32'd0);
    checkOutput("midrst_addr", 32'(dm.addr_dec), 32'd0);
    checkOutput("midrst_valid", 32'(valid_flag), 32'd0);
    reset_n = 1'b1;
    applyStimulus("post_reset", 1'b0);

    // Held start: no rescan, then a one-cycle drop retriggers
    fillConst(8'h61);
    mem[9] = 8'h5B;
    applyStimulus("hold_first", 1'b1);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!done_flag || dm.rd_active || dm.addr_dec != 8'd9) errs++;
    end
    checkOutput("hold_no_rescan", 32'(errs), 32'd0);
    start_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("hold_drop_done", 32'(done_flag), 32'd0);
    checkOutput("hold_drop_bad", 32'(bad_index), 32'd9);
    applyStimulus("hold_second", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
